// File: rtl/tm1638_board_scanner.sv
// TM1638 LED&KEY board controller: refreshes digits, LEDs and brightness every frame
// and reads the eight board keys back through the shared DIO pin.
module tm1638_board_scanner #(
    parameter int CLK_DIV    = 8,
    parameter int N_DIGITS   = 8,
    parameter int READ_WAIT  = 16,
    parameter int GAP_CYCLES = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [8*N_DIGITS-1:0]   digits,
    input  logic [N_DIGITS-1:0]     leds,
    input  logic [2:0]              brightness,
    input  logic                    display_on,
    output logic [7:0]              keys,
    output logic                    keys_valid,
    output logic                    frame_done,
    output logic                    tm1638_clk,
    output logic                    tm1638_stb,
    input  logic                    tm1638_dio_in,
    output logic                    tm1638_dio_out,
    output logic                    tm1638_dio_out_en
);

    localparam int BYTE_W   = $clog2(2*N_DIGITS+2);
    localparam int DIV_W    = $clog2(CLK_DIV+1);
    localparam int WAIT_MAX = (READ_WAIT > GAP_CYCLES) ? READ_WAIT : GAP_CYCLES;
    localparam int WAIT_W   = $clog2(WAIT_MAX+1);

    localparam logic [DIV_W-1:0]  DIV_LOAD  = DIV_W'(CLK_DIV-1);
    localparam logic [WAIT_W-1:0] GAP_LOAD  = WAIT_W'(GAP_CYCLES-1);
    localparam logic [WAIT_W-1:0] RW_LOAD   = WAIT_W'((READ_WAIT > 0) ? READ_WAIT-1 : 0);
    localparam logic [BYTE_W-1:0] LAST_T2   = BYTE_W'(2*N_DIGITS);
    localparam logic [BYTE_W-1:0] BYTE_ONE  = BYTE_W'(1);
    localparam logic [BYTE_W-1:0] BYTE_RD_LAST = BYTE_W'(3);

    localparam logic [2:0] ST_GAP       = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_SHIFT_OUT = 3'd2;
    localparam logic [2:0] ST_RD_WAIT   = 3'd3;
    localparam logic [2:0] ST_SHIFT_IN  = 3'd4;
    localparam logic [2:0] ST_STOP      = 3'd5;

    logic [2:0]              state_r;
    logic [1:0]              txn_r;
    logic [BYTE_W-1:0]       byte_r;
    logic [2:0]              bit_r;
    logic [DIV_W-1:0]        div_r;
    logic [WAIT_W-1:0]       wait_r;
    logic [8*N_DIGITS-1:0]   dig_r;
    logic [N_DIGITS-1:0]     led_r;
    logic [7:0]              disp_r;
    logic [7:0]              keys_sh_r;
    logic [7:0]              keys_r;
    logic                    keys_valid_r;
    logic                    frame_done_r;
    logic                    clk_r;
    logic                    stb_r;
    logic                    dio_r;
    logic                    dio_en_r;

    logic [BYTE_W-1:0]       idx_s;
    logic [BYTE_W-1:0]       last_s;
    logic [7:0]              cur_byte_s;
    logic [2:0]              nxt_bit_s;

    // Byte idx of transaction txn, taken from the frame snapshot.
    function automatic logic [7:0] byte_of(
        input logic [1:0]              txn,
        input logic [BYTE_W-1:0]       idx,
        input logic [8*N_DIGITS-1:0]   dig,
        input logic [N_DIGITS-1:0]     led,
        input logic [7:0]              disp
    );
        logic [BYTE_W-1:0]     j;
        logic [8*N_DIGITS-1:0] dsh;
        logic [N_DIGITS-1:0]   lsh;
        logic [7:0]            r;
        j   = idx - BYTE_ONE;
        dsh = dig >> {j[BYTE_W-1:1], 3'b000};
        lsh = led >> j[BYTE_W-1:1];
        case (txn)
            2'd0: r = 8'h40;
            2'd1: begin
                if (idx == '0) begin
                    r = 8'hC0;
                end else if (j[0] == 1'b0) begin
                    r = dsh[7:0];
                end else begin
                    r = {7'b0000000, lsh[0]};
                end
            end
            2'd2: r = disp;
            2'd3: r = 8'h42;
            default: r = 8'h42;
        endcase
        return r;
    endfunction

    // At the last bit of a byte, look ahead so the next byte's bit 0 is ready when clk falls.
    always_comb begin
        idx_s = byte_r;
        if (state_r == ST_SHIFT_OUT && bit_r == 3'd7) begin
            idx_s = byte_r + BYTE_ONE;
        end else begin
            idx_s = byte_r;
        end
        last_s     = (txn_r == 2'd1) ? LAST_T2 : '0;
        cur_byte_s = byte_of(txn_r, idx_s, dig_r, led_r, disp_r);
        nxt_bit_s  = (bit_r == 3'd7) ? 3'd0 : bit_r + 3'd1;
    end

    // Frame sequencer: drives the serial pins and collects key bits.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r      <= ST_GAP;
            txn_r        <= 2'd0;
            byte_r       <= '0;
            bit_r        <= 3'd0;
            div_r        <= '0;
            wait_r       <= GAP_LOAD;
            dig_r        <= '0;
            led_r        <= '0;
            disp_r       <= 8'h80;
            keys_sh_r    <= 8'h00;
            keys_r       <= 8'h00;
            keys_valid_r <= 1'b0;
            frame_done_r <= 1'b0;
            clk_r        <= 1'b1;
            stb_r        <= 1'b1;
            dio_r        <= 1'b1;
            dio_en_r     <= 1'b0;
        end else begin
            keys_valid_r <= 1'b0;
            frame_done_r <= 1'b0;
            case (state_r)
                ST_GAP: begin
                    if (txn_r == 2'd0 && wait_r == GAP_LOAD) begin
                        dig_r  <= digits;
                        led_r  <= leds;
                        disp_r <= display_on ? {5'b10001, brightness} : 8'h80;
                    end
                    if (wait_r == '0) begin
                        state_r  <= ST_START;
                        stb_r    <= 1'b0;
                        dio_en_r <= 1'b1;
                        div_r    <= DIV_LOAD;
                        byte_r   <= '0;
                        bit_r    <= 3'd7;
                    end else begin
                        wait_r <= wait_r - WAIT_W'(1);
                    end
                end
                ST_START: begin
                    if (div_r == '0) begin
                        state_r <= ST_SHIFT_OUT;
                        clk_r   <= 1'b0;
                        dio_r   <= cur_byte_s[nxt_bit_s];
                        bit_r   <= nxt_bit_s;
                        div_r   <= DIV_LOAD;
                    end else begin
                        div_r <= div_r - DIV_W'(1);
                    end
                end
                ST_SHIFT_OUT: begin
                    if (div_r != '0) begin
                        div_r <= div_r - DIV_W'(1);
                    end else if (!clk_r) begin
                        clk_r <= 1'b1;
                        div_r <= DIV_LOAD;
                    end else if (bit_r != 3'd7) begin
                        clk_r <= 1'b0;
                        dio_r <= cur_byte_s[nxt_bit_s];
                        bit_r <= nxt_bit_s;
                        div_r <= DIV_LOAD;
                    end else if (txn_r == 2'd3) begin
                        state_r  <= ST_RD_WAIT;
                        dio_en_r <= 1'b0;
                        wait_r   <= RW_LOAD;
                    end else if (byte_r != last_s) begin
                        byte_r <= byte_r + BYTE_ONE;
                        clk_r  <= 1'b0;
                        dio_r  <= cur_byte_s[nxt_bit_s];
                        bit_r  <= nxt_bit_s;
                        div_r  <= DIV_LOAD;
                    end else begin
                        state_r <= ST_STOP;
                        div_r   <= DIV_LOAD;
                    end
                end
                ST_RD_WAIT: begin
                    if (wait_r == '0) begin
                        state_r <= ST_SHIFT_IN;
                        clk_r   <= 1'b0;
                        div_r   <= DIV_LOAD;
                        bit_r   <= 3'd0;
                        byte_r  <= '0;
                    end else begin
                        wait_r <= wait_r - WAIT_W'(1);
                    end
                end
                ST_SHIFT_IN: begin
                    if (div_r != '0) begin
                        div_r <= div_r - DIV_W'(1);
                    end else if (!clk_r) begin
                        clk_r <= 1'b1;
                        div_r <= DIV_LOAD;
                    end else begin
                        // Only bits 0 and 4 of each read byte carry keys on this board.
                        if (bit_r == 3'd0) begin
                            keys_sh_r[{1'b0, byte_r[1:0]}] <= tm1638_dio_in;
                        end else if (bit_r == 3'd4) begin
                            keys_sh_r[{1'b1, byte_r[1:0]}] <= tm1638_dio_in;
                        end else begin
                            keys_sh_r <= keys_sh_r;
                        end
                        if (bit_r != 3'd7) begin
                            bit_r <= nxt_bit_s;
                            clk_r <= 1'b0;
                            div_r <= DIV_LOAD;
                        end else if (byte_r != BYTE_RD_LAST) begin
                            byte_r <= byte_r + BYTE_ONE;
                            bit_r  <= 3'd0;
                            clk_r  <= 1'b0;
                            div_r  <= DIV_LOAD;
                        end else begin
                            state_r  <= ST_STOP;
                            dio_en_r <= 1'b1;
                            div_r    <= DIV_LOAD;
                        end
                    end
                end
                ST_STOP: begin
                    if (div_r == '0) begin
                        state_r  <= ST_GAP;
                        stb_r    <= 1'b1;
                        clk_r    <= 1'b1;
                        dio_r    <= 1'b1;
                        dio_en_r <= 1'b0;
                        wait_r   <= GAP_LOAD;
                        if (txn_r == 2'd3) begin
                            txn_r        <= 2'd0;
                            keys_r       <= keys_sh_r;
                            keys_valid_r <= 1'b1;
                            frame_done_r <= 1'b1;
                        end else begin
                            txn_r <= txn_r + 2'd1;
                        end
                    end else begin
                        div_r <= div_r - DIV_W'(1);
                    end
                end
                default: begin
                    state_r  <= ST_GAP;
                    txn_r    <= 2'd0;
                    wait_r   <= GAP_LOAD;
                    clk_r    <= 1'b1;
                    stb_r    <= 1'b1;
                    dio_r    <= 1'b1;
                    dio_en_r <= 1'b0;
                end
            endcase
        end
    end

    assign keys              = keys_r;
    assign keys_valid        = keys_valid_r;
    assign frame_done        = frame_done_r;
    assign tm1638_clk        = clk_r;
    assign tm1638_stb        = stb_r;
    assign tm1638_dio_out    = dio_r;
    assign tm1638_dio_out_en = dio_en_r;

endmodule

// File: tb/tb_tm1638_board_scanner.sv
// Directed bench for tm1638_board_scanner: a TM1638 bus model decodes written bytes,
// answers key reads, and frames are compared against hand-built expected byte lists.
module tb_tm1638_board_scanner;

    localparam int CLK_DIV    = 2;
    localparam int N_DIGITS   = 8;
    localparam int READ_WAIT  = 6;
    localparam int GAP_CYCLES = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] digits;
    logic [7:0]  leds;
    logic [2:0]  brightness;
    logic        display_on;
    logic [7:0]  keys;
    logic        keys_valid;
    logic        frame_done;
    logic        tm1638_clk;
    logic        tm1638_stb;
    logic        tm1638_dio_in = 1'b1;
    logic        tm1638_dio_out;
    logic        tm1638_dio_out_en;

    int n_vec = 0;
    int n_bad = 0;

    logic [7:0] cap_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] rd_bytes[4];

    logic       prev_clk = 1'b1;
    logic       prev_stb = 1'b1;
    logic [7:0] wsh = 8'h00;
    logic [7:0] rtmp;
    logic       is_t4 = 1'b0;
    int wbits = 0, rbits = 0, txn_bytes = 0, en_low = 0;
    int t4_en_low = -1, other_en_low = 0, proto_viol = 0, kv_cnt = 0;

    always #5 clock = ~clock;

    tm1638_board_scanner #(
        .CLK_DIV(CLK_DIV), .N_DIGITS(N_DIGITS), .READ_WAIT(READ_WAIT), .GAP_CYCLES(GAP_CYCLES)
    ) dut (
        .clock(clock), .reset(reset), .digits(digits), .leds(leds),
        .brightness(brightness), .display_on(display_on), .keys(keys),
        .keys_valid(keys_valid), .frame_done(frame_done), .tm1638_clk(tm1638_clk),
        .tm1638_stb(tm1638_stb), .tm1638_dio_in(tm1638_dio_in),
        .tm1638_dio_out(tm1638_dio_out), .tm1638_dio_out_en(tm1638_dio_out_en)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // TM1638 bus model: decodes bytes on clk rising edges and answers key reads.
    always @(negedge clock) begin
        if (reset) begin
            wbits = 0; rbits = 0; txn_bytes = 0; en_low = 0; is_t4 = 1'b0;
        end else begin
            if (tm1638_stb && !tm1638_clk) proto_viol++;
            if ((tm1638_stb != prev_stb) && !(tm1638_clk && prev_clk)) proto_viol++;
            if (!tm1638_stb) begin
                if (!tm1638_dio_out_en) en_low++;
                if (!prev_clk && tm1638_clk) begin
                    if (tm1638_dio_out_en) begin
                        wsh = {tm1638_dio_out, wsh[7:1]};
                        wbits++;
                        if (wbits == 8) begin
                            cap_q.push_back(wsh);
                            if (txn_bytes == 0 && wsh == 8'h42) is_t4 = 1'b1;
                            txn_bytes++;
                            wbits = 0;
                        end
                    end else begin
                        rbits++;
                    end
                end
                if (prev_clk && !tm1638_clk && !tm1638_dio_out_en && rbits < 32) begin
                    rtmp = rd_bytes[rbits / 8];
                    tm1638_dio_in = rtmp[rbits % 8];
                end
            end
            if (!prev_stb && tm1638_stb) begin
                if (is_t4) t4_en_low = en_low;
                else other_en_low += en_low;
                en_low = 0; wbits = 0; rbits = 0; txn_bytes = 0; is_t4 = 1'b0;
                tm1638_dio_in = 1'b1;
            end
            if (keys_valid) kv_cnt++;
        end
        prev_clk = tm1638_clk;
        prev_stb = tm1638_stb;
    end

    function automatic logic [7:0] exp_keys();
        logic [7:0] k;
        for (int b = 0; b < 4; b++) begin
            k[b]     = rd_bytes[b][0];
            k[b + 4] = rd_bytes[b][4];
        end
        return k;
    endfunction

    task automatic build_exp(input logic [63:0] d, input logic [7:0] l, input logic [2:0] br,
                             input logic on);
        exp_q.delete();
        exp_q.push_back(8'h40);
        exp_q.push_back(8'hC0);
        for (int i = 0; i < N_DIGITS; i++) begin
            exp_q.push_back(d[8*i +: 8]);
            exp_q.push_back({7'b0000000, l[i]});
        end
        exp_q.push_back(on ? (8'h88 | {5'b00000, br}) : 8'h80);
        exp_q.push_back(8'h42);
    endtask

    task automatic wait_frame();
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clock); #1;
            if (frame_done) begin
                ok = 1'b1;
                break;
            end
        end
        check_eq("frame_seen", {31'd0, ok}, 32'd1);
    endtask

    task automatic wait_bytes(input int n);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clock); #1;
            if (cap_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
        check_eq("bytes_seen", {31'd0, ok}, 32'd1);
    endtask

    task automatic check_frame(input string tag);
        check_eq({tag, "_nbytes"}, cap_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            check_eq($sformatf("%s_byte%0d", tag, i),
                     (i < cap_q.size()) ? {24'd0, cap_q[i]} : 32'hFFFF_FFFF, {24'd0, exp_q[i]});
        end
        check_eq({tag, "_keys"}, {24'd0, keys}, {24'd0, exp_keys()});
        check_eq({tag, "_kv_pulses"}, kv_cnt, 1);
        check_eq({tag, "_rd_en_low"}, t4_en_low, READ_WAIT + 64*CLK_DIV);
        check_eq({tag, "_wr_en_low"}, other_en_low, 0);
        cap_q.delete();
        kv_cnt = 0;
        other_en_low = 0;
        t4_en_low = -1;
    endtask

    initial begin
        digits     = 64'h0706050403020100;
        leds       = 8'hA5;
        brightness = 3'd7;
        display_on = 1'b1;
        rd_bytes   = '{8'h00, 8'h10, 8'h00, 8'h01};
        reset      = 1'b1;
        repeat (3) @(negedge clock);
        check_eq("rst_stb", {31'd0, tm1638_stb}, 32'd1);
        check_eq("rst_clk", {31'd0, tm1638_clk}, 32'd1);
        check_eq("rst_dio", {31'd0, tm1638_dio_out}, 32'd1);
        check_eq("rst_en", {31'd0, tm1638_dio_out_en}, 32'd0);
        check_eq("rst_keys", {24'd0, keys}, 32'd0);
        check_eq("rst_kv", {31'd0, keys_valid}, 32'd0);
        check_eq("rst_fd", {31'd0, frame_done}, 32'd0);
        reset = 1'b0;
        cap_q.delete(); kv_cnt = 0; other_en_low = 0; t4_en_low = -1;

        // Frame 1: base pattern, keys 00,10,00,01
        wait_frame();
        build_exp(64'h0706050403020100, 8'hA5, 3'd7, 1'b1);
        check_frame("f1");
        brightness = 3'd3;
        display_on = 1'b0;

        // Frame 2: display off
        wait_frame();
        build_exp(64'h0706050403020100, 8'hA5, 3'd3, 1'b0);
        check_frame("f2");
        display_on = 1'b1;
        rd_bytes   = '{8'h11, 8'h01, 8'h10, 8'h00};

        // Frame 3: display on at brightness 3, different key pattern
        wait_frame();
        build_exp(64'h0706050403020100, 8'hA5, 3'd3, 1'b1);
        check_frame("f3");
        digits   = 64'h3F06_5B4F_6672_7D07;
        leds     = 8'h3C;
        rd_bytes = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};

        // Frame 4: inputs change mid-T2, old snapshot must still go out
        wait_bytes(6);
        digits = 64'h0102_0408_1020_4080;
        leds   = 8'hC3;
        wait_frame();
        build_exp(64'h3F06_5B4F_6672_7D07, 8'h3C, 3'd3, 1'b1);
        check_frame("f4");

        // Frame 5: new values picked up
        wait_frame();
        build_exp(64'h0102_0408_1020_4080, 8'hC3, 3'd3, 1'b1);
        check_frame("f5");

        // Reset in the middle of T2
        wait_bytes(5);
        reset = 1'b1;
        @(negedge clock);
        check_eq("midrst_stb", {31'd0, tm1638_stb}, 32'd1);
        check_eq("midrst_clk", {31'd0, tm1638_clk}, 32'd1);
        check_eq("midrst_en", {31'd0, tm1638_dio_out_en}, 32'd0);
        check_eq("midrst_keys", {24'd0, keys}, 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        cap_q.delete(); kv_cnt = 0; other_en_low = 0; t4_en_low = -1;
        wait_frame();
        check_eq("midrst_first", (cap_q.size() > 0) ? {24'd0, cap_q[0]} : 32'hFFFF_FFFF, 32'h40);
        build_exp(64'h0102_0408_1020_4080, 8'hC3, 3'd3, 1'b1);
        check_frame("f6");

        check_eq("protocol_violations", proto_viol, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
